ring_decoder: RTL and testbench

- Receive-side companion to the team's 8-bit one-hot ring counter: samples a ring-count bus and decodes the active bit to a binary index.
- Checks that the sequence advances by exactly one position per valid sample. Rotation is left-shift with wrap, so bit WIDTH-1 is followed by bit 0.
- Reports lock status, one-hot and sequence errors, and completed revolutions.
- Sits downstream of any ring-counter source as a monitor/decoder feeding control logic.

---
 rtl/ring_pkg.sv | 18 +
 rtl/ring_decoder_onehot_to_bin.sv | 31 +++
 rtl/ring_decoder.sv | 182 ++++++++++++++++++
 tb/tb_ring_decoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared definitions for the ring-counter decoder: tracking states,
// default ring width and the ring successor helper.
package ring_pkg;

    localparam int RING_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } ring_state_e;

    // Next position on a left-rotating ring: WIDTH-1 wraps to 0.
    function automatic int unsigned ring_succ(input int unsigned i, input int unsigned width);
        return (i + 1 >= width) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/ring_decoder_onehot_to_bin.sv
// Combinational one-hot to binary converter. o_legal is high only when
// exactly one input bit is set; o_idx is the position of the highest set bit.
module onehot_to_bin #(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_onehot,
    output logic [IDXW-1:0]  o_idx,
    output logic             o_legal
);

    logic w_seen;
    logic w_multi;

    // Scan all bits, remembering the position and whether a second bit appears.
    always_comb begin
        o_idx   = '0;
        w_seen  = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_onehot[i]) begin
                if (w_seen) w_multi = 1'b1;
                w_seen = 1'b1;
                o_idx  = IDXW'(i);
            end
        end
    end

    assign o_legal = w_seen & ~w_multi;

endmodule

// File: rtl/ring_decoder.sv
// Ring-counter receive decoder: decodes a one-hot ring bus to an index,
// checks single-step left rotation, tracks lock and counts revolutions.
// Optional sticky error flags are built when RING_DECODER_STICKY_EN is defined.
//
// Sampling handshake: ring_in is consumed on every posedge where ring_vld=1;
// there is no backpressure. Every output is registered and reflects the
// sample one cycle later; pulses last exactly one cycle.
module ring_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH    = RING_WIDTH_DEF,
    parameter int IDXW     = $clog2(WIDTH),
    parameter int REV_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic              clk,
    input  logic              init,
    input  logic [WIDTH-1:0]  ring_in,
    input  logic              ring_vld,
    output logic [IDXW-1:0]   idx,
    output logic              idx_vld,
    output logic              onehot_err,
    output logic              seq_err,
    output logic              locked,
    output logic [REV_W-1:0]  rev_cnt,
    output logic              rev_tick,
`ifdef RING_DECODER_STICKY_EN
    input  logic              err_clr,
    output logic [1:0]        err_sticky,
`endif
    output ring_state_e       state_dbg
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    ring_state_e      r_state;
    ring_state_e      w_state_nxt;
    logic [GW-1:0]    r_good;
    logic [GW-1:0]    w_good_nxt;
    logic [GW-1:0]    w_good_inc;
    logic [IDXW-1:0]  r_idx;
    logic [IDXW-1:0]  w_idx_nxt;
    logic             r_idx_vld;
    logic             w_idx_vld_nxt;
    logic             r_onehot_err;
    logic             w_onehot_err_nxt;
    logic             r_seq_err;
    logic             w_seq_err_nxt;
    logic [REV_W-1:0] r_rev_cnt;
    logic [REV_W-1:0] w_rev_cnt_nxt;
    logic             r_rev_tick;
    logic             w_rev_tick_nxt;

    logic [IDXW-1:0]  w_dec_idx;
    logic             w_legal;
    logic [IDXW-1:0]  w_exp;
    logic             w_match;

    onehot_to_bin #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_dec (
        .i_onehot (ring_in),
        .o_idx    (w_dec_idx),
        .o_legal  (w_legal)
    );

    assign w_exp      = IDXW'(ring_succ(32'(r_idx), WIDTH));
    assign w_match    = (w_dec_idx == w_exp);
    assign w_good_inc = r_good + GW'(1);

    // Next-state and next-output decode for one valid sample.
    always_comb begin
        w_state_nxt      = r_state;
        w_good_nxt       = r_good;
        w_idx_nxt        = r_idx;
        w_idx_vld_nxt    = 1'b0;
        w_onehot_err_nxt = 1'b0;
        w_seq_err_nxt    = 1'b0;
        w_rev_cnt_nxt    = r_rev_cnt;
        w_rev_tick_nxt   = 1'b0;
        if (ring_vld) begin
            if (!w_legal) begin
                w_onehot_err_nxt = 1'b1;
                w_state_nxt      = HUNT;
                w_good_nxt       = '0;
            end else begin
                w_idx_nxt     = w_dec_idx;
                w_idx_vld_nxt = 1'b1;
                case (r_state)
                    HUNT: begin
                        w_state_nxt = TRACK;
                        w_good_nxt  = '0;
                    end
                    TRACK: begin
                        if (w_match) begin
                            if (w_good_inc == GW'(LOCK_CNT)) begin
                                w_state_nxt = LOCKED;
                                w_good_nxt  = '0;
                            end else begin
                                w_good_nxt = w_good_inc;
                            end
                        end else begin
                            w_seq_err_nxt = 1'b1;
                            w_good_nxt    = '0;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            // A correct step onto position 0 closes a revolution.
                            if (w_dec_idx == '0) begin
                                w_rev_tick_nxt = 1'b1;
                                w_rev_cnt_nxt  = r_rev_cnt + REV_W'(1);
                            end
                        end else begin
                            w_seq_err_nxt = 1'b1;
                            w_state_nxt   = TRACK;
                            w_good_nxt    = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = HUNT;
                        w_good_nxt  = '0;
                    end
                endcase
            end
        end
    end

    // State and registered outputs; init overrides any sample on the same edge.
    always_ff @(posedge clk) begin
        if (init) begin
            r_state      <= HUNT;
            r_good       <= '0;
            r_idx        <= '0;
            r_idx_vld    <= 1'b0;
            r_onehot_err <= 1'b0;
            r_seq_err    <= 1'b0;
            r_rev_cnt    <= '0;
            r_rev_tick   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_good       <= w_good_nxt;
            r_idx        <= w_idx_nxt;
            r_idx_vld    <= w_idx_vld_nxt;
            r_onehot_err <= w_onehot_err_nxt;
            r_seq_err    <= w_seq_err_nxt;
            r_rev_cnt    <= w_rev_cnt_nxt;
            r_rev_tick   <= w_rev_tick_nxt;
        end
    end

    assign idx        = r_idx;
    assign idx_vld    = r_idx_vld;
    assign onehot_err = r_onehot_err;
    assign seq_err    = r_seq_err;
    assign locked     = (r_state == LOCKED);
    assign rev_cnt    = r_rev_cnt;
    assign rev_tick   = r_rev_tick;
    assign state_dbg  = r_state;

`ifdef RING_DECODER_STICKY_EN
    logic [1:0] r_sticky;
    logic [1:0] w_sticky_nxt;

    // A new error sets its flag even when err_clr is asserted on the same edge.
    always_comb begin
        w_sticky_nxt    = r_sticky & {2{~err_clr}};
        w_sticky_nxt[0] = w_sticky_nxt[0] | w_onehot_err_nxt;
        w_sticky_nxt[1] = w_sticky_nxt[1] | w_seq_err_nxt;
    end

    // Sticky flag register.
    always_ff @(posedge clk) begin
        if (init) r_sticky <= 2'b00;
        else      r_sticky <= w_sticky_nxt;
    end

    assign err_sticky = r_sticky;
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// Directed testbench for ring_decoder (WIDTH=8, REV_W=8, LOCK_CNT=2).
// Sticky-flag scenarios run when RING_DECODER_STICKY_EN is defined.
module tb_ring_decoder;
    import ring_pkg::*;

    logic        clk;
    logic        init;
    logic [7:0]  ring_in;
    logic        ring_vld;
    logic [2:0]  idx;
    logic        idx_vld;
    logic        onehot_err;
    logic        seq_err;
    logic        locked;
    logic [7:0]  rev_cnt;
    logic        rev_tick;
    ring_state_e state_dbg;
`ifdef RING_DECODER_STICKY_EN
    logic        err_clr;
    logic [1:0]  err_sticky;
`endif

    int checks   = 0;
    int failures = 0;

    ring_decoder #(.WIDTH(8), .IDXW(3), .REV_W(8), .LOCK_CNT(2)) dut (
        .clk        (clk),
        .init       (init),
        .ring_in    (ring_in),
        .ring_vld   (ring_vld),
        .idx        (idx),
        .idx_vld    (idx_vld),
        .onehot_err (onehot_err),
        .seq_err    (seq_err),
        .locked     (locked),
        .rev_cnt    (rev_cnt),
        .rev_tick   (rev_tick),
`ifdef RING_DECODER_STICKY_EN
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
`endif
        .state_dbg  (state_dbg)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Observed output bundle: {state, idx, idx_vld, onehot_err, seq_err, locked, rev_tick, rev_cnt}.
    logic [17:0] obs;
    assign obs = {state_dbg, idx, idx_vld, onehot_err, seq_err, locked, rev_tick, rev_cnt};

    function automatic logic [17:0] mk(input ring_state_e s, input logic [2:0] i, input logic v,
                                       input logic oh, input logic sq, input logic lk,
                                       input logic tk, input logic [7:0] rc);
        return {s, i, v, oh, sq, lk, tk, rc};
    endfunction

    // Driver: apply inputs on the falling edge, return 1 time unit after the rising edge.
    task automatic drive(input logic ini, input logic vld, input logic [7:0] val);
        @(negedge clk);
        init     = ini;
        ring_vld = vld;
        ring_in  = val;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] e;
        drive(1'b1, 1'b0, 8'h00);
        e = mk(HUNT, 3'd0, 0, 0, 0, 0, 0, 8'd0);
        checks++; if (obs !== e) begin failures++; $display("FAIL reset got=%h exp=%h", obs, e); end
    endtask

    task automatic test_lock();
        logic [17:0] e;
        drive(1'b0, 1'b1, 8'h80);
        e = mk(TRACK, 3'd7, 1, 0, 0, 0, 0, 8'd0);
        checks++; if (obs !== e) begin failures++; $display("FAIL lock_first got=%h exp=%h", obs, e); end
        drive(1'b0, 1'b1, 8'h01);
        e = mk(TRACK, 3'd0, 1, 0, 0, 0, 0, 8'd0);
        checks++; if (obs !== e) begin failures++; $display("FAIL lock_wrap_in_track got=%h exp=%h", obs, e); end
        drive(1'b0, 1'b1, 8'h02);
        e = mk(LOCKED, 3'd1, 1, 0, 0, 1, 0, 8'd0);
        checks++; if (obs !== e) begin failures++; $display("FAIL lock_reached got=%h exp=%h", obs, e); end
    endtask

    task automatic test_revolution();
        logic [17:0] e;
        logic [7:0]  exp_rev;
        int          ticks;
        for (int p = 2; p < 8; p++) begin
            drive(1'b0, 1'b1, 8'(1 << p));
            e = mk(LOCKED, 3'(p), 1, 0, 0, 1, 0, 8'd0);
            checks++; if (obs !== e) begin failures++; $display("FAIL rev_walk p=%0d got=%h exp=%h", p, obs, e); end
        end
        drive(1'b0, 1'b1, 8'h01);
        e = mk(LOCKED, 3'd0, 1, 0, 0, 1, 1, 8'd1);
        checks++; if (obs !== e) begin failures++; $display("FAIL rev_first_tick got=%h exp=%h", obs, e); end
        // 256 more revolutions: the 8-bit counter wraps back to 1.
        exp_rev = 8'd1;
        ticks   = 0;
        for (int r = 0; r < 256; r++) begin
            for (int k = 1; k <= 8; k++) begin
                drive(1'b0, 1'b1, 8'(1 << (k % 8)));
                if (k == 8) exp_rev = exp_rev + 8'd1;
                e = mk(LOCKED, 3'(k % 8), 1, 0, 0, 1, (k == 8), exp_rev);
                checks++; if (obs !== e) begin failures++; $display("FAIL rev_loop r=%0d k=%0d got=%h exp=%h", r, k, obs, e); end
                if (rev_tick === 1'b1) ticks++;
            end
        end
        checks++; if (ticks != 256) begin failures++; $display("FAIL rev_tick_count got=%0d exp=256", ticks); end
        checks++; if (rev_cnt !== 8'd1) begin failures++; $display("FAIL rev_wrap got=%0d exp=1", rev_cnt); end
    endtask

    task automatic test_seq_err();
        logic [17:0] e;
        drive(1'b0, 1'b1, 8'h02);
        drive(1'b0, 1'b1, 8'h04);
        e = mk(LOCKED, 3'd2, 1, 0, 0, 1, 0, 8'd1);
        checks++; if (obs !== e) begin failures++; $display("FAIL seq_pre got=%h exp=%h", obs, e); end
        drive(1'b0, 1'b1, 8'h10);
        e = mk(TRACK, 3'd4, 1, 0, 1, 0, 0, 8'd1);
        checks++; if (obs !== e) begin failures++; $display("FAIL seq_skip got=%h exp=%h", obs, e); end
        drive(1'b0, 1'b1, 8'h10);
        e = mk(TRACK, 3'd4, 1, 0, 1, 0, 0, 8'd1);
        checks++; if (obs !== e) begin failures++; $display("FAIL seq_hold got=%h exp=%h", obs, e); end
    endtask

    task automatic test_onehot_err();
        logic [17:0] e;
        drive(1'b0, 1'b1, 8'h00);
        e = mk(HUNT, 3'd4, 0, 1, 0, 0, 0, 8'd1);
        checks++; if (obs !== e) begin failures++; $display("FAIL onehot_zero got=%h exp=%h", obs, e); end
        drive(1'b0, 1'b1, 8'h03);
        e = mk(HUNT, 3'd4, 0, 1, 0, 0, 0, 8'd1);
        checks++; if (obs !== e) begin failures++; $display("FAIL onehot_multi got=%h exp=%h", obs, e); end
    endtask

    task automatic test_idle();
        logic [17:0] e;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 8'h5A);
            e = mk(HUNT, 3'd4, 0, 0, 0, 0, 0, 8'd1);
            checks++; if (obs !== e) begin failures++; $display("FAIL idle c=%0d got=%h exp=%h", c, obs, e); end
        end
    endtask

    task automatic test_init_locked();
        logic [17:0] e;
        drive(1'b0, 1'b1, 8'h01);
        drive(1'b0, 1'b0, 8'hFF);
        drive(1'b0, 1'b1, 8'h02);
        drive(1'b0, 1'b1, 8'h04);
        e = mk(LOCKED, 3'd2, 1, 0, 0, 1, 0, 8'd1);
        checks++; if (obs !== e) begin failures++; $display("FAIL relock_gap got=%h exp=%h", obs, e); end
        drive(1'b1, 1'b1, 8'h08);
        e = mk(HUNT, 3'd0, 0, 0, 0, 0, 0, 8'd0);
        checks++; if (obs !== e) begin failures++; $display("FAIL init_locked got=%h exp=%h", obs, e); end
    endtask

`ifdef RING_DECODER_STICKY_EN
    task automatic test_sticky();
        drive(1'b0, 1'b1, 8'h01);
        drive(1'b0, 1'b1, 8'h04);
        checks++; if (err_sticky !== 2'b10) begin failures++; $display("FAIL sticky_seq got=%b exp=10", err_sticky); end
        drive(1'b0, 1'b1, 8'h00);
        checks++; if (err_sticky !== 2'b11) begin failures++; $display("FAIL sticky_both got=%b exp=11", err_sticky); end
        err_clr = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
        checks++; if (err_sticky !== 2'b00) begin failures++; $display("FAIL sticky_clr got=%b exp=00", err_sticky); end
        drive(1'b0, 1'b1, 8'h01);
        err_clr = 1'b1;
        drive(1'b0, 1'b1, 8'h08);
        err_clr = 1'b0;
        checks++; if (err_sticky !== 2'b10) begin failures++; $display("FAIL sticky_set_wins got=%b exp=10", err_sticky); end
    endtask
`endif

    initial begin
        init     = 1'b1;
        ring_vld = 1'b0;
        ring_in  = 8'h00;
`ifdef RING_DECODER_STICKY_EN
        err_clr  = 1'b0;
`endif
        test_reset();
        test_lock();
        test_revolution();
        test_seq_err();
        test_onehot_err();
        test_idle();
        test_init_locked();
`ifdef RING_DECODER_STICKY_EN
        test_sticky();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
